wb_bus_master: RTL and testbench
================================

// Module: wb_bus_master
// PURPOSE
//   Wishbone classic single-transfer initiator. Converts a core-side valid/ready request port
//   into one Wishbone cycle at a time and returns read data or error status on a response port.
//   Sits between a CPU/DMA client and the system bus, opposite the memory/peripheral slaves.
//   Handles ack, err and rty terminations, including bounded reissue on rty.
// PARAMETERS
//   ADDR_W          32   address width; adr_o and req_addr
//   DATA_W          32   data width; sel width is DATA_W/8
//   MAX_RETRY       4    rty terminations tolerated before the request completes with error
//   TIMEOUT_CYCLES  256  cycles in BUS without termination before abort (WB_MASTER_TIMEOUT_EN only)
// PORTS
//   clk_bus     in   1         bus clock; all state changes on posedge
//   rst_bus     in   1         asynchronous reset, active high
//   req_valid   in   1         client request present
//   req_ready   out  1         request accepted on a cycle where req_valid && req_ready
//   req_we      in   1         1 = write, 0 = read
//   req_addr    in   ADDR_W    byte address, passed to adr_o unchanged
//   req_wdata   in   DATA_W    write data
//   req_sel     in   DATA_W/8  byte lane enables
//   resp_valid  out  1         response present; held until resp_ready
//   resp_ready  in   1         client consumes response
//   resp_rdata  out  DATA_W    read data (0 for writes and errors)
//   resp_err    out  1         1 = err_i, retry exhaustion, or timeout
//   cyc_o stb_o we_o  out 1    Wishbone cycle, strobe, write enable
//   adr_o       out  ADDR_W    Wishbone address
//   dat_o       out  DATA_W    Wishbone write data
//   sel_o       out  DATA_W/8  Wishbone byte select
//   dat_i       in   DATA_W    Wishbone read data
//   ack_i err_i rty_i  in  1   Wishbone terminations
// BEHAVIOUR
//   - Reset: state IDLE; cyc_o/stb_o/we_o=0, adr_o/dat_o/sel_o=0, resp_valid=0, resp_err=0,
//     resp_rdata=0, retry counter=0. Reset mid-cycle drops cyc_o/stb_o immediately (async).
//   - All outputs are registered; req_ready = (state==IDLE) is the only combinational output.
//   - States: IDLE -> BUS -> {RESP | BACKOFF}; BACKOFF -> {BUS | RESP}; RESP -> IDLE.
//   - IDLE: on accept, latch we/addr/wdata/sel into adr_o/dat_o/sel_o/we_o, set cyc_o=stb_o=1,
//     retry counter=0, go to BUS.
//   - BUS: hold all Wishbone outputs stable. Sample terminations with priority err_i > ack_i > rty_i.
//     err_i: resp_err=1, resp_rdata=0, go to RESP. ack_i: capture dat_i into resp_rdata (reads only;
//     writes load 0), resp_err=0, go to RESP. In both cases cyc_o=stb_o=0 on the same edge.
//     rty_i: cyc_o=stb_o=0. If counter==MAX_RETRY go to RESP with resp_err=1; else increment and go to BACKOFF.
//   - BACKOFF: exactly one idle cycle with cyc_o=0. Then reassert cyc_o=stb_o with unchanged
//     adr/dat/sel/we and return to BUS.
//   - RESP: resp_valid=1 until sampled with resp_ready=1. Then go to IDLE and set resp_valid=0.
//     req_ready stays 0 until then (no overlap).
//   - Latency against a one-cycle registered-ack slave: accept at edge N, stb high after N,
//     ack sampled at N+2, resp_valid high after N+2. Minimum request spacing is 4 cycles with resp_ready tied 1.
//   - Terminations sampled outside BUS are ignored. cyc_o never drops while stb_o is high.
// CONFIGURATION
//   WB_MASTER_TIMEOUT_EN defined: a cycle counter clears on entering BUS. If it reaches
//     TIMEOUT_CYCLES-1 with no termination, drop cyc_o/stb_o and go to RESP with resp_err=1.
//     A termination on that same cycle wins over the timeout.
//   Not defined: no counter; BUS waits indefinitely. The parameter is still declared but unused.
// STRUCTURE
//   Package wb_bus_pkg: state enum {IDLE, BUS, BACKOFF, RESP}; WB_SEL_W(DATA_W) helper;
//     shared termination-code typedef {TERM_ACK, TERM_ERR, TERM_RTY, TERM_TMO}.
//   One sub-module: wb_term_timer. It implements the retry counter and the optional timeout counter,
//     with clear/inc inputs and exhausted/expired outputs.
//   The FSM and data registers stay in wb_bus_master.
// TESTING
//   1 Read 0x0000_0010, slave acks 1 cycle after stb with dat_i=0xDEAD_BEEF
//     -> one stb pulse, resp_rdata=0xDEAD_BEEF, resp_err=0.
//   2 Write 0x0000_0020 data 0x1234_5678 sel=4'b0011
//     -> we_o=1, dat_o/sel_o match for the whole cycle; resp_rdata=0, resp_err=0.
//   3 Slave asserts rty_i twice, then ack_i -> two 1-cycle BACKOFF gaps with cyc_o=0,
//     identical adr_o on 3 strobes, resp_err=0.
//   4 rty_i on every attempt, MAX_RETRY=4 -> exactly 5 strobes, then resp_err=1.
//   5 err_i and ack_i asserted together -> resp_err=1, resp_rdata=0.
//   6 rst_bus pulsed while in BUS -> cyc_o/stb_o low without a clock edge; next request proceeds normally.
//   7 With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, silent slave -> abort after 8 BUS cycles, resp_err=1.

Source files
------------

// File: rtl/wb_bus_pkg.sv
// wb_bus_pkg: shared state/termination types and the byte-select width helper
//   for the Wishbone single-transfer master.
package wb_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;
  typedef enum logic [1:0] {TERM_ACK, TERM_ERR, TERM_RTY, TERM_TMO} term_t;
  function automatic int WB_SEL_W(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/wb_bus_master_if.sv
// wb_bus_master_if: client request/response port plus Wishbone initiator signals.
//   master modport: the initiator (wb_bus_master); slave modport: client and bus side.
//   req_*  : valid/ready request (we, addr, wdata, sel)
//   resp_* : valid/ready response (rdata, err)
//   cyc_o stb_o we_o adr_o dat_o sel_o / dat_i ack_i err_i rty_i : Wishbone classic
interface wb_bus_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import wb_bus_pkg::*;
  localparam int SEL_W = WB_SEL_W(DATA_W);
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SEL_W-1:0] req_sel;
  logic resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic cyc_o, stb_o, we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o, dat_i;
  logic [SEL_W-1:0] sel_o;
  logic ack_i, err_i, rty_i;
  modport master(
    input req_valid, req_we, req_addr, req_wdata, req_sel, resp_ready, dat_i, ack_i, err_i, rty_i,
    output req_ready, resp_valid, resp_rdata, resp_err, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );
  modport slave(
    output req_valid, req_we, req_addr, req_wdata, req_sel, resp_ready, dat_i, ack_i, err_i, rty_i,
    input req_ready, resp_valid, resp_rdata, resp_err, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );
endinterface

// File: rtl/wb_bus_master_term_timer.sv
// wb_term_timer: retry counter and optional bus-cycle timeout counter.
//   clk, rst               : clock, async active-high reset
//   retry_clr, retry_inc   : clear / increment the retry count
//   tmr_clr, tmr_run       : clear / advance the timeout count
//   exhausted              : retry count has reached MAX_RETRY
//   expired                : timeout count at TIMEOUT_CYCLES-1 (always 0 unless WB_MASTER_TIMEOUT_EN)
module wb_term_timer #(
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic retry_clr,
  input  logic retry_inc,
  input  logic tmr_clr,
  input  logic tmr_run,
  output logic exhausted,
  output logic expired
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) retry_cnt <= '0;
    else if (retry_clr) retry_cnt <= '0;
    else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
  assign exhausted = retry_cnt == RW'(MAX_RETRY);
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmr_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmr_cnt <= '0;
    else if (tmr_clr) tmr_cnt <= '0;
    else if (tmr_run) tmr_cnt <= tmr_cnt + 1'b1;
  assign expired = tmr_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_tmo;
  assign unused_tmo = |{TIMEOUT_CYCLES, tmr_clr, tmr_run};
  assign expired = 1'b0;
`endif
endmodule

// File: rtl/wb_bus_master.sv
// wb_bus_master: Wishbone classic single-transfer initiator with bounded rty reissue.
//   clk_bus, rst_bus : bus clock, async active-high reset
//   bus              : wb_bus_master_if.master (client req/resp + Wishbone signals)
//   Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_bus_master
  import wb_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk_bus,
  input logic rst_bus,
  wb_bus_master_if.master bus
);
  localparam int SEL_W = WB_SEL_W(DATA_W);
  state_t state, nxt;
  term_t term;
  logic hit, exhausted, expired, retry_clr, retry_inc;
  logic cyc_n, stb_n, we_n, rv_n, re_n;
  logic [ADDR_W-1:0] adr_n;
  logic [DATA_W-1:0] dat_n, rd_n;
  logic [SEL_W-1:0] sel_n;
  wb_term_timer #(.MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk_bus),
    .rst(rst_bus),
    .retry_clr(retry_clr),
    .retry_inc(retry_inc),
    .tmr_clr(nxt == BUS && state != BUS),
    .tmr_run(state == BUS),
    .exhausted(exhausted),
    .expired(expired)
  );
  assign bus.req_ready = state == IDLE;
  // A real termination on the expiry cycle takes precedence over the timeout.
  assign hit = bus.err_i | bus.ack_i | bus.rty_i | expired;
  assign term = bus.err_i ? TERM_ERR : bus.ack_i ? TERM_ACK : bus.rty_i ? TERM_RTY : TERM_TMO;
  always_comb begin
    nxt = state;
    cyc_n = bus.cyc_o;
    stb_n = bus.stb_o;
    we_n = bus.we_o;
    adr_n = bus.adr_o;
    dat_n = bus.dat_o;
    sel_n = bus.sel_o;
    rv_n = bus.resp_valid;
    re_n = bus.resp_err;
    rd_n = bus.resp_rdata;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        nxt = BUS;
        cyc_n = 1'b1;
        stb_n = 1'b1;
        we_n = bus.req_we;
        adr_n = bus.req_addr;
        dat_n = bus.req_wdata;
        sel_n = bus.req_sel;
        retry_clr = 1'b1;
      end
      BUS: if (hit) begin
        cyc_n = 1'b0;
        stb_n = 1'b0;
        if (term == TERM_RTY && !exhausted) begin
          nxt = BACKOFF;
          retry_inc = 1'b1;
        end else begin
          nxt = RESP;
          rv_n = 1'b1;
          re_n = term != TERM_ACK;
          rd_n = (term == TERM_ACK && !bus.we_o) ? bus.dat_i : '0;
        end
      end
      BACKOFF: begin
        nxt = BUS;
        cyc_n = 1'b1;
        stb_n = 1'b1;
      end
      RESP: if (bus.resp_ready) begin
        nxt = IDLE;
        rv_n = 1'b0;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_bus or posedge rst_bus)
    if (rst_bus) begin
      state <= IDLE;
      bus.cyc_o <= 1'b0;
      bus.stb_o <= 1'b0;
      bus.we_o <= 1'b0;
      bus.adr_o <= '0;
      bus.dat_o <= '0;
      bus.sel_o <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      state <= nxt;
      bus.cyc_o <= cyc_n;
      bus.stb_o <= stb_n;
      bus.we_o <= we_n;
      bus.adr_o <= adr_n;
      bus.dat_o <= dat_n;
      bus.sel_o <= sel_n;
      bus.resp_valid <= rv_n;
      bus.resp_err <= re_n;
      bus.resp_rdata <= rd_n;
    end
endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master: table-driven bench with a scripted registered-response Wishbone slave.
module tb_wb_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wb_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus();
  wb_bus_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_bus(clk),
    .rst_bus(rst),
    .bus(bus)
  );
  // slave codes: 0 ack, 1 err, 2 rty, 3 err+ack, 4 silent
  typedef struct {
    logic we;
    logic [31:0] addr, wdata;
    logic [3:0] sel;
    logic [23:0] script;
    int ncodes;
    logic [31:0] sdata, exp_rdata;
    logic exp_err;
    int exp_strobes, exp_gaps, exp_lat;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic err;
  } exp_t;
  exp_t sb[$];
  int codes[$];
  int total = 0, bad = 0;
  int strobes, gaps, viol, cur;
  logic prev_stb = 1'b0, active = 1'b0, pending = 1'b0, term_on = 1'b0;
  logic exp_we;
  logic [31:0] exp_adr, exp_dat;
  logic [3:0] exp_sel;
  vec_t vt[7];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask
  // Registered slave: sees stb on one edge, answers for one cycle after the next.
  initial forever begin
    @(posedge clk);
    #1;
    if (term_on) begin
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      bus.rty_i = 1'b0;
      term_on = 1'b0;
      pending = 1'b0;
    end else if (!bus.cyc_o) pending = 1'b0;
    else if (pending) begin
      if (cur != 4) begin
        bus.ack_i = cur == 0 || cur == 3;
        bus.err_i = cur == 1 || cur == 3;
        bus.rty_i = cur == 2;
        term_on = 1'b1;
      end
    end else if (bus.stb_o) begin
      cur = codes.size() != 0 ? codes.pop_front() : 0;
      pending = 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.stb_o && !prev_stb) strobes++;
    if (bus.stb_o && !bus.cyc_o) viol++;
    if (bus.cyc_o && (bus.adr_o !== exp_adr || bus.we_o !== exp_we || bus.dat_o !== exp_dat || bus.sel_o !== exp_sel)) viol++;
    if (active && !bus.cyc_o && !bus.resp_valid) gaps++;
    prev_stb = bus.stb_o;
  end
  task automatic start_req(input vec_t v);
    int wt;
    bus.dat_i = v.sdata;
    for (int i = 0; i < v.ncodes; i++) codes.push_back(int'(v.script[4*i +: 4]));
    sb.push_back('{v.exp_rdata, v.exp_err});
    strobes = 0;
    gaps = 0;
    viol = 0;
    exp_we = v.we;
    exp_adr = v.addr;
    exp_dat = v.wdata;
    exp_sel = v.sel;
    bus.req_valid = 1'b1;
    bus.req_we = v.we;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_sel = v.sel;
    wt = 0;
    while (!bus.req_ready && wt < 20) begin
      @(posedge clk);
      #1;
      wt++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    active = 1'b1;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    active = 1'b0;
  endtask
  task automatic check_resp(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, ".rdata"}, bus.resp_rdata, e.rdata);
    check({tag, ".err"}, 32'(bus.resp_err), 32'(e.err));
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    start_req(v);
    wait_resp(lat);
    check_resp(tag);
    check({tag, ".strobes"}, strobes, v.exp_strobes);
    check({tag, ".gaps"}, gaps, v.exp_gaps);
    check({tag, ".stable"}, viol, 0);
    check({tag, ".latency"}, lat, v.exp_lat);
    @(posedge clk);
    #1;
    codes.delete();
  endtask
  initial begin
    int lat;
    vec_t v;
    vt[0] = '{1'b0, 32'h10, 32'h0, 4'hf, 24'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, 0, 2};
    vt[1] = '{1'b1, 32'h20, 32'h12345678, 4'b0011, 24'h0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 0, 2};
    vt[2] = '{1'b0, 32'h30, 32'h0, 4'hf, 24'h000022, 3, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 2, 8};
    vt[3] = '{1'b0, 32'h40, 32'h0, 4'hf, 24'h022222, 5, 32'h11111111, 32'h0, 1'b1, 5, 4, 14};
    vt[4] = '{1'b0, 32'h50, 32'h0, 4'hf, 24'h3, 1, 32'h55AA55AA, 32'h0, 1'b1, 1, 0, 2};
    vt[5] = '{1'b1, 32'h60, 32'hA5A5A5A5, 4'b1100, 24'h1, 1, 32'h77777777, 32'h0, 1'b1, 1, 0, 2};
    vt[6] = '{1'b0, 32'h70, 32'h0, 4'hf, 24'h002222, 5, 32'h00000001, 32'h00000001, 1'b0, 5, 4, 14};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_sel = '0;
    bus.resp_ready = 1'b1;
    bus.dat_i = '0;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.cyc", 32'(bus.cyc_o), 0);
    check("rst.stb", 32'(bus.stb_o), 0);
    check("rst.we", 32'(bus.we_o), 0);
    check("rst.adr", bus.adr_o, 0);
    check("rst.dat", bus.dat_o, 0);
    check("rst.sel", 32'(bus.sel_o), 0);
    check("rst.resp_valid", 32'(bus.resp_valid), 0);
    check("rst.resp_err", 32'(bus.resp_err), 0);
    check("rst.resp_rdata", bus.resp_rdata, 0);
    check("rst.req_ready", 32'(bus.req_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vt[i]);
    bus.resp_ready = 1'b0;
    v = vt[0];
    v.addr = 32'h90;
    v.sdata = 32'h0BADCAFE;
    v.exp_rdata = 32'h0BADCAFE;
    start_req(v);
    wait_resp(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d.resp_valid", i), 32'(bus.resp_valid), 1);
      check($sformatf("hold%0d.req_ready", i), 32'(bus.req_ready), 0);
    end
    check_resp("hold");
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold.release_valid", 32'(bus.resp_valid), 0);
    check("hold.release_ready", 32'(bus.req_ready), 1);
    codes.delete();
    v = vt[0];
    v.addr = 32'h80;
    v.script = 24'h4;
    start_req(v);
    void'(sb.pop_back());
    @(posedge clk);
    #2;
    check("mid.cyc_busy", 32'(bus.cyc_o), 1);
    rst = 1'b1;
    #1;
    check("mid.cyc", 32'(bus.cyc_o), 0);
    check("mid.stb", 32'(bus.stb_o), 0);
    check("mid.req_ready", 32'(bus.req_ready), 1);
    #2;
    rst = 1'b0;
    active = 1'b0;
    codes.delete();
    @(posedge clk);
    #1;
    run_vec("after_rst", vt[0]);
`ifdef WB_MASTER_TIMEOUT_EN
    v = vt[0];
    v.addr = 32'hA0;
    v.script = 24'h4;
    v.exp_rdata = 32'h0;
    v.exp_err = 1'b1;
    v.exp_lat = 8;
    run_vec("timeout", v);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
